// File: rtl/stream_demux.sv
// Registered 1-to-N stream demultiplexer with per-channel output slots,
// broadcast mode and a saturating counter for out-of-range selectors.
module stream_demux #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8,
    parameter int SEL_W    = 2,
    parameter int CNT_W    = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          in_data,
    input  logic [SEL_W-1:0]          in_sel,
    input  logic                      in_bcast,
    output logic [CHANNELS-1:0]       out_valid,
    input  logic [CHANNELS-1:0]       out_ready,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic [CNT_W-1:0]          drop_cnt,
    output logic                      busy
);

    logic [CHANNELS-1:0]       valid_q;
    logic [CHANNELS*WIDTH-1:0] data_q;
    logic [CNT_W-1:0]          drop_q;
    logic [CHANNELS-1:0]       free;
    logic [CHANNELS-1:0]       load;
    logic                      sel_ok;
    logic                      sel_free;
    logic                      xfer;
    logic                      drop;

    // A slot that drains this cycle can be reloaded in the same cycle.
    assign free   = ~valid_q | out_ready;
    assign sel_ok = 32'(in_sel) < 32'(CHANNELS);

    always_comb begin
        sel_free = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (in_sel == SEL_W'(i)) sel_free = free[i];
        end
    end

    always_comb begin
        in_ready = 1'b0;
        if (!rst_n)        in_ready = 1'b0;
        else if (in_bcast) in_ready = &free;
        else if (sel_ok)   in_ready = sel_free;
        else               in_ready = 1'b1;
    end

    assign xfer = in_valid && in_ready;
    assign drop = xfer && !in_bcast && !sel_ok;

    always_comb begin
        load = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            load[i] = xfer && (in_bcast || in_sel == SEL_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            data_q  <= '0;
            drop_q  <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (load[i]) begin
                    valid_q[i]              <= 1'b1;
                    data_q[i*WIDTH +: WIDTH] <= in_data;
                end else if (valid_q[i] && out_ready[i]) begin
                    valid_q[i]              <= 1'b0;
                    data_q[i*WIDTH +: WIDTH] <= '0;
                end
            end
            if (drop && drop_q != '1) drop_q <= drop_q + 1'b1;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign drop_cnt  = drop_q;
    assign busy      = |valid_q;

endmodule

// File: tb/tb_stream_demux.sv
// Directed self-checking bench for stream_demux: default 4-channel
// instance plus a 3-channel instance for out-of-range drops.
module tb_stream_demux;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [1:0]  in_sel;
    logic        in_bcast;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] out_data;
    logic [7:0]  drop_cnt;
    logic        busy;

    logic        d_valid;
    logic        d_ready;
    logic [7:0]  d_data;
    logic [1:0]  d_sel;
    logic        d_bcast;
    logic [2:0]  d_out_valid;
    logic [2:0]  d_out_ready;
    logic [23:0] d_out_data;
    logic [1:0]  d_drop_cnt;
    logic        d_busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    stream_demux u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_bcast  (in_bcast),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .drop_cnt  (drop_cnt),
        .busy      (busy)
    );

    stream_demux #(
        .CHANNELS (3),
        .WIDTH    (8),
        .SEL_W    (2),
        .CNT_W    (2)
    ) u_drop (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (d_valid),
        .in_ready  (d_ready),
        .in_data   (d_data),
        .in_sel    (d_sel),
        .in_bcast  (d_bcast),
        .out_valid (d_out_valid),
        .out_ready (d_out_ready),
        .out_data  (d_out_data),
        .drop_cnt  (d_drop_cnt),
        .busy      (d_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [1:0] sel, input logic [7:0] data);
        in_valid = 1'b1;
        in_bcast = 1'b0;
        in_sel   = sel;
        in_data  = data;
        #1;
    endtask

    logic [1:0] drop_exp [5];

    initial begin
        drop_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

        rst_n       = 1'b0;
        in_valid    = 1'b1;
        in_data     = 8'hEE;
        in_sel      = 2'd0;
        in_bcast    = 1'b0;
        out_ready   = 4'hF;
        d_valid     = 1'b0;
        d_data      = 8'h00;
        d_sel       = 2'd0;
        d_bcast     = 1'b0;
        d_out_ready = 3'b111;

        // reset with in_valid high
        repeat (3) tick();
        chk("rst_in_ready", 64'(in_ready), 64'(1'b0));
        chk("rst_out_valid", 64'(out_valid), 64'(4'b0000));
        chk("rst_out_data", 64'(out_data), 64'(32'h0));
        chk("rst_drop_cnt", 64'(drop_cnt), 64'(8'd0));
        chk("rst_busy", 64'(busy), 64'(1'b0));
        in_valid = 1'b0;
        rst_n    = 1'b1;
        tick();

        // unicast sweep
        out_ready = 4'hF;
        for (int k = 0; k < 4; k++) begin
            send(2'(k), 8'hA0 + 8'(k));
            chk("uni_in_ready", 64'(in_ready), 64'(1'b1));
            tick();
            chk("uni_valid", 64'(out_valid), 64'(4'b0001 << k));
            chk("uni_data", 64'(out_data),
                64'({24'h0, 8'hA0 + 8'(k)} << (8 * k)));
        end
        in_valid = 1'b0;
        tick();
        chk("uni_idle_valid", 64'(out_valid), 64'(4'b0000));
        chk("uni_idle_data", 64'(out_data), 64'(32'h0));

        // stall isolation
        out_ready = 4'b1101;
        send(2'd1, 8'h11);
        chk("st_rdy_11", 64'(in_ready), 64'(1'b1));
        tick();
        chk("st_valid_11", 64'(out_valid), 64'(4'b0010));
        chk("st_data_11", 64'(out_data), 64'(32'h0000_1100));
        chk("st_busy", 64'(busy), 64'(1'b1));
        send(2'd1, 8'h12);
        chk("st_rdy_12", 64'(in_ready), 64'(1'b0));
        tick();
        chk("st_hold_valid", 64'(out_valid), 64'(4'b0010));
        chk("st_hold_data", 64'(out_data), 64'(32'h0000_1100));
        send(2'd2, 8'h22);
        chk("st_rdy_22", 64'(in_ready), 64'(1'b1));
        tick();
        chk("st_valid_22", 64'(out_valid), 64'(4'b0110));
        chk("st_data_22", 64'(out_data), 64'(32'h0022_1100));
        out_ready = 4'hF;
        send(2'd1, 8'h12);
        chk("st_rdy_12b", 64'(in_ready), 64'(1'b1));
        tick();
        chk("st_valid_12", 64'(out_valid), 64'(4'b0010));
        chk("st_data_12", 64'(out_data), 64'(32'h0000_1200));
        in_valid = 1'b0;
        tick();
        chk("st_idle_valid", 64'(out_valid), 64'(4'b0000));
        chk("st_idle_data", 64'(out_data), 64'(32'h0));

        // broadcast blocked by a stalled channel, then released
        out_ready = 4'b0111;
        send(2'd3, 8'h33);
        tick();
        chk("bc_pre_valid", 64'(out_valid), 64'(4'b1000));
        in_bcast = 1'b1;
        in_data  = 8'h5A;
        in_sel   = 2'd0;
        #1;
        chk("bc_rdy_blocked", 64'(in_ready), 64'(1'b0));
        tick();
        chk("bc_blk_valid", 64'(out_valid), 64'(4'b1000));
        chk("bc_blk_data", 64'(out_data), 64'(32'h3300_0000));
        out_ready = 4'hF;
        #1;
        chk("bc_rdy_open", 64'(in_ready), 64'(1'b1));
        tick();
        chk("bc_valid", 64'(out_valid), 64'(4'b1111));
        chk("bc_data", 64'(out_data), 64'(32'h5A5A_5A5A));
        in_valid = 1'b0;
        in_bcast = 1'b0;
        tick();
        chk("bc_idle_valid", 64'(out_valid), 64'(4'b0000));

        // back-to-back on channel 0
        out_ready = 4'hF;
        for (int k = 1; k <= 3; k++) begin
            send(2'd0, 8'(k));
            chk("b2b_rdy", 64'(in_ready), 64'(1'b1));
            tick();
            chk("b2b_valid", 64'(out_valid), 64'(4'b0001));
            chk("b2b_data", 64'(out_data), 64'(32'(k)));
        end
        in_valid = 1'b0;
        tick();
        chk("b2b_end_valid", 64'(out_valid), 64'(4'b0000));
        chk("b2b_end_data", 64'(out_data), 64'(32'h0));
        chk("b2b_drop_cnt", 64'(drop_cnt), 64'(8'd0));

        // out-of-range drops on the 3-channel instance
        for (int k = 0; k < 5; k++) begin
            d_valid = 1'b1;
            d_sel   = 2'd3;
            d_data  = 8'hC0 + 8'(k);
            #1;
            chk("drop_rdy", 64'(d_ready), 64'(1'b1));
            tick();
            chk("drop_valid", 64'(d_out_valid), 64'(3'b000));
            chk("drop_data", 64'(d_out_data), 64'(24'h0));
            chk("drop_cnt", 64'(d_drop_cnt), 64'(drop_exp[k]));
        end
        d_valid = 1'b0;
        tick();
        chk("drop_busy", 64'(d_busy), 64'(1'b0));
        chk("drop_hold", 64'(d_drop_cnt), 64'(2'd3));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
